// File: rtl/dpram_pkg.sv
// Shared types and the byte-lane merge helper for the byte-enable dual-port RAM.
// The merge function is width-generic up to MAX_DATA_W; callers cast in and out.
package dpram_pkg;

    typedef enum logic {
        READ_FIRST  = 1'b0,
        WRITE_FIRST = 1'b1
    } rdw_mode_e;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

    localparam int MAX_DATA_W = 256;
    localparam int MAX_NB     = 256;
    localparam int MAX_NB_W   = 8;

    // Lanes whose enable is set come from new_word, all others from old_word.
    function automatic logic [MAX_DATA_W-1:0] merge_bytes(
        input logic [MAX_DATA_W-1:0] old_word,
        input logic [MAX_DATA_W-1:0] new_word,
        input logic [MAX_NB-1:0]     be,
        input int                    byte_width
    );
        logic [MAX_DATA_W-1:0] merged;
        merged = old_word;
        for (int i = 0; i < MAX_DATA_W; i++) begin
            if (be[MAX_NB_W'(i / byte_width)]) begin
                merged[i] = new_word[i];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/dpram_clear_fsm.sv
// Post-reset memory clear sequencer: walks every address once, writing zero,
// and holds busy high for exactly 2**ADDR_WIDTH cycles after reset falls.
module dpram_clear_fsm
    import dpram_pkg::*;
#(
    parameter int ADDR_WIDTH     = 8,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr,
    output logic                  busy
);

    clr_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        clr_we  = 1'b0;
        case (state_q)
            CLEAR: begin
                clr_we = !rst;
                addr_d = addr_q + ADDR_WIDTH'(1);
                if (addr_q == '1) begin
                    state_d = IDLE;
                end
            end
            default: ;
        endcase
    end

    // NOTE: non-blocking updates so every flop samples the pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    assign clr_addr = addr_q;
    assign busy     = (state_q == CLEAR);

endmodule

// File: rtl/dpram_be.sv
// Simple dual-port RAM with byte enables, 1- or 2-cycle read latency,
// selectable read-during-write behaviour and an optional clear after reset.
module dpram_be
    import dpram_pkg::*;
#(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int BYTE_WIDTH     = 8,
    parameter int READ_LATENCY   = 1,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             write_en,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] byte_en,
    input  logic [ADDR_WIDTH-1:0]            WAdddr,
    input  logic [DATA_WIDTH-1:0]            dataIn,
    input  logic                             read_en,
    input  logic [ADDR_WIDTH-1:0]            RAdddr,
    output logic [DATA_WIDTH-1:0]            dataOut,
    output logic                             data_valid,
    output logic                             busy
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int NB    = DATA_WIDTH / BYTE_WIDTH;

    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("dpram_be: READ_LATENCY must be 1 or 2");
    end
    if ((DATA_WIDTH % BYTE_WIDTH) != 0 || DATA_WIDTH > MAX_DATA_W) begin : g_bad_width
        $error("dpram_be: DATA_WIDTH must be a multiple of BYTE_WIDTH and at most MAX_DATA_W");
    end
    if (RDW_MODE != 0 && RDW_MODE != 1) begin : g_bad_rdw
        $error("dpram_be: RDW_MODE must be 0 or 1");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  accept, wr_accept, rd_accept;
    logic [DATA_WIDTH-1:0] rd_word;

    dpram_clear_fsm #(
        .ADDR_WIDTH     (ADDR_WIDTH),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear (
        .clk      (clk),
        .rst      (rst),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .busy     (busy)
    );

    always_comb begin
        accept    = !busy && !rst;
        wr_accept = write_en && accept;
        rd_accept = read_en && accept;
        rd_word   = mem[RAdddr];
        // Write-first forwarding: a colliding read sees the lanes being written this cycle.
        if (RDW_MODE == int'(WRITE_FIRST) && wr_accept && (WAdddr == RAdddr)) begin
            rd_word = DATA_WIDTH'(merge_bytes(MAX_DATA_W'(mem[RAdddr]), MAX_DATA_W'(dataIn),
                                              MAX_NB'(byte_en), BYTE_WIDTH));
        end
    end

    // NOTE: the array has no reset; zeroing is done by the clear sequencer so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (wr_accept) begin
            for (int b = 0; b < NB; b++) begin
                if (byte_en[b]) begin
                    mem[WAdddr][b*BYTE_WIDTH +: BYTE_WIDTH] <= dataIn[b*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d, out_data_q, out_data_d;
        logic                  s1_valid_q, s1_valid_d, out_valid_q, out_valid_d;

        always_comb begin
            s1_valid_d  = rd_accept;
            s1_data_d   = rd_accept ? rd_word : s1_data_q;
            out_valid_d = s1_valid_q;
            out_data_d  = s1_valid_q ? s1_data_q : out_data_q;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                s1_valid_q  <= 1'b0;
                s1_data_q   <= '0;
                out_valid_q <= 1'b0;
                out_data_q  <= '0;
            end else begin
                s1_valid_q  <= s1_valid_d;
                s1_data_q   <= s1_data_d;
                out_valid_q <= out_valid_d;
                out_data_q  <= out_data_d;
            end
        end

        assign dataOut    = out_data_q;
        assign data_valid = out_valid_q;
    end else begin : g_lat1
        logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
        logic                  out_valid_q, out_valid_d;

        always_comb begin
            out_valid_d = rd_accept;
            out_data_d  = rd_accept ? rd_word : out_data_q;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                out_valid_q <= 1'b0;
                out_data_q  <= '0;
            end else begin
                out_valid_q <= out_valid_d;
                out_data_q  <= out_data_d;
            end
        end

        assign dataOut    = out_data_q;
        assign data_valid = out_valid_q;
    end

endmodule

// File: tb/tb_dpram_be.sv
// Bench for dpram_be: two instances share stimulus (latency 1 read-first, latency 2
// write-first) and are compared every cycle against a word-level model plus literal checks.
module tb_dpram_be;

    localparam int DEPTH = 256;

    logic        clk;
    logic        rst;
    logic        write_en;
    logic [3:0]  byte_en;
    logic [7:0]  WAdddr;
    logic [31:0] dataIn;
    logic        read_en;
    logic [7:0]  RAdddr;
    logic [31:0] dout0, dout1;
    logic        valid0, valid1, busy0, busy1;

    int n_checks = 0;
    int n_fail   = 0;

    dpram_be #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .BYTE_WIDTH(8),
               .READ_LATENCY(1), .RDW_MODE(0), .CLEAR_ON_RESET(1)) dut0 (
        .clk(clk), .rst(rst), .write_en(write_en), .byte_en(byte_en), .WAdddr(WAdddr),
        .dataIn(dataIn), .read_en(read_en), .RAdddr(RAdddr), .dataOut(dout0),
        .data_valid(valid0), .busy(busy0)
    );

    dpram_be #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .BYTE_WIDTH(8),
               .READ_LATENCY(2), .RDW_MODE(1), .CLEAR_ON_RESET(1)) dut1 (
        .clk(clk), .rst(rst), .write_en(write_en), .byte_en(byte_en), .WAdddr(WAdddr),
        .dataIn(dataIn), .read_en(read_en), .RAdddr(RAdddr), .dataOut(dout1),
        .data_valid(valid1), .busy(busy1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
        end
    endtask

    // ---------------- word-level model ----------------
    typedef struct {
        int          due;
        logic [31:0] data;
    } rd_t;

    logic [31:0] mem_m [DEPTH];
    rd_t         q0[$], q1[$];
    int          edge_n     = 0;
    int          busy_left  = 0;
    bit          model_live = 1'b0;
    logic [31:0] exp_data0 = '0, exp_data1 = '0;
    logic        exp_valid0 = 1'b0, exp_valid1 = 1'b0, exp_busy = 1'b0;

    function automatic logic [31:0] lane_merge(input logic [31:0] o, input logic [31:0] n,
                                               input logic [3:0] be);
        logic [31:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (n & mask) | (o & ~mask);
    endfunction

    initial begin
        logic        acc;
        logic [31:0] old_w;
        rd_t         r;
        forever begin
            @(posedge clk);
            edge_n++;
            if (rst) begin
                // Nothing can observe the array while busy, so zero it in one go.
                busy_left = DEPTH;
                foreach (mem_m[i]) mem_m[i] = '0;
                q0.delete();
                q1.delete();
                exp_data0  = '0;
                exp_data1  = '0;
                exp_valid0 = 1'b0;
                exp_valid1 = 1'b0;
                model_live = 1'b1;
            end else begin
                acc = (busy_left == 0);
                if (busy_left > 0) busy_left--;
                if (acc && read_en) begin
                    old_w = mem_m[RAdddr];
                    q0.push_back('{edge_n, old_w});
                    if (write_en && WAdddr == RAdddr)
                        q1.push_back('{edge_n + 1, lane_merge(old_w, dataIn, byte_en)});
                    else
                        q1.push_back('{edge_n + 1, old_w});
                end
                if (acc && write_en) mem_m[WAdddr] = lane_merge(mem_m[WAdddr], dataIn, byte_en);
                exp_valid0 = 1'b0;
                if (q0.size() > 0 && q0[0].due == edge_n) begin
                    r = q0.pop_front();
                    exp_valid0 = 1'b1;
                    exp_data0  = r.data;
                end
                exp_valid1 = 1'b0;
                if (q1.size() > 0 && q1[0].due == edge_n) begin
                    r = q1.pop_front();
                    exp_valid1 = 1'b1;
                    exp_data1  = r.data;
                end
            end
            exp_busy = (busy_left > 0);
        end
    end

    // Per-cycle comparison, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (model_live) begin
                check("cmp_valid0", 32'(valid0), 32'(exp_valid0));
                check("cmp_data0",  dout0,       exp_data0);
                check("cmp_busy0",  32'(busy0),  32'(exp_busy));
                check("cmp_valid1", 32'(valid1), 32'(exp_valid1));
                check("cmp_data1",  dout1,       exp_data1);
                check("cmp_busy1",  32'(busy1),  32'(exp_busy));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [7:0] wa, input logic [31:0] wd,
                         input logic [3:0] be, input logic re, input logic [7:0] ra);
        write_en = we;
        WAdddr   = wa;
        dataIn   = wd;
        byte_en  = be;
        read_en  = re;
        RAdddr   = ra;
    endtask

    task automatic idle();
        drive(1'b0, 8'h00, 32'h0, 4'h0, 1'b0, 8'h00);
    endtask

    task automatic wait_busy_low(output int cnt);
        cnt = 0;
        while (busy0 && cnt < 400) begin
            step();
            cnt++;
        end
    endtask

    // One read (optionally with a same-cycle write); e0/e1 are the words each instance returns.
    task automatic read_check(input string tag, input logic [7:0] ra, input logic we,
                              input logic [7:0] wa, input logic [31:0] wd, input logic [3:0] be,
                              input logic [31:0] e0, input logic [31:0] e1);
        drive(we, wa, wd, be, 1'b1, ra);
        step();
        idle();
        @(negedge clk);
        check({tag, "_v0"}, 32'(valid0), 32'h1);
        check({tag, "_d0"}, dout0, e0);
        @(negedge clk);
        check({tag, "_v1"}, 32'(valid1), 32'h1);
        check({tag, "_d1"}, dout1, e1);
        step();
    endtask

    initial begin
        int cnt;
        rst = 1'b1;
        idle();
        step();
        step();
        check("rst_dout0",  dout0,       32'h0);
        check("rst_valid0", 32'(valid0), 32'h0);
        check("rst_busy0",  32'(busy0),  32'h1);
        check("rst_dout1",  dout1,       32'h0);
        check("rst_valid1", 32'(valid1), 32'h0);
        check("rst_busy1",  32'(busy1),  32'h1);
        rst = 1'b0;
        wait_busy_low(cnt);
        check("init_clear_len", 32'(cnt), 32'd256);

        // Fill with ones, then a one-cycle reset must clear everything in 256 cycles.
        for (int a = 0; a < DEPTH; a++) begin
            drive(1'b1, 8'(a), 32'hFFFF_FFFF, 4'hF, 1'b0, 8'h00);
            step();
        end
        idle();
        read_check("pre_clear", 8'd200, 1'b0, 8'd0, 32'h0, 4'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        rst = 1'b1;
        step();
        rst = 1'b0;
        wait_busy_low(cnt);
        check("clear_len", 32'(cnt), 32'd256);
        for (int a = 0; a < DEPTH; a++) begin
            drive(1'b0, 8'h00, 32'h0, 4'h0, 1'b1, 8'(a));
            step();
        end
        idle();
        step();
        step();
        read_check("post_clear", 8'd255, 1'b0, 8'd0, 32'h0, 4'h0, 32'h0, 32'h0);

        // Byte enables.
        drive(1'b1, 8'd5, 32'hAABB_CCDD, 4'b1111, 1'b0, 8'd0);
        step();
        drive(1'b1, 8'd5, 32'h1122_3344, 4'b0101, 1'b0, 8'd0);
        step();
        idle();
        read_check("byte_en", 8'd5, 1'b0, 8'd0, 32'h0, 4'h0, 32'hAA22_CC44, 32'hAA22_CC44);

        // Collision on address 7: read-first vs write-first, then the stored word.
        read_check("collide", 8'd7, 1'b1, 8'd7, 32'hDEAD_BEEF, 4'b0011, 32'h0000_0000, 32'h0000_BEEF);
        read_check("collide_after", 8'd7, 1'b0, 8'd0, 32'h0, 4'h0, 32'h0000_BEEF, 32'h0000_BEEF);

        // Back-to-back reads through the two-cycle pipeline.
        drive(1'b1, 8'd1, 32'h1111_1111, 4'hF, 1'b0, 8'd0); step();
        drive(1'b1, 8'd2, 32'h2222_2222, 4'hF, 1'b0, 8'd0); step();
        drive(1'b1, 8'd3, 32'h3333_3333, 4'hF, 1'b0, 8'd0); step();
        idle();
        step();
        drive(1'b0, 8'd0, 32'h0, 4'h0, 1'b1, 8'd1);
        step();
        drive(1'b0, 8'd0, 32'h0, 4'h0, 1'b1, 8'd2);
        @(negedge clk);
        check("lat_d0_first", dout0, 32'h1111_1111);
        check("lat_v1_early", 32'(valid1), 32'h0);
        step();
        drive(1'b0, 8'd0, 32'h0, 4'h0, 1'b1, 8'd3);
        @(negedge clk);
        check("lat_v1_a", 32'(valid1), 32'h1);
        check("lat_d1_a", dout1, 32'h1111_1111);
        step();
        idle();
        @(negedge clk);
        check("lat_v1_b", 32'(valid1), 32'h1);
        check("lat_d1_b", dout1, 32'h2222_2222);
        step();
        @(negedge clk);
        check("lat_v1_c", 32'(valid1), 32'h1);
        check("lat_d1_c", dout1, 32'h3333_3333);
        step();
        @(negedge clk);
        check("lat_v1_end", 32'(valid1), 32'h0);
        check("lat_d1_hold", dout1, 32'h3333_3333);
        step();

        // Mixed burst with frequent collisions and partial/zero byte enables.
        for (int i = 0; i < 16; i++) begin
            drive((i % 3) != 2, 8'(32 + i % 4), 32'h0102_0304 * 32'(i + 1), 4'(i),
                  (i % 4) != 3, 8'(32 + (3 * i) % 4));
            step();
        end
        idle();
        repeat (3) step();

        // Reset restarted mid-clear; requests during the clear are dropped.
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (49) step();
        drive(1'b1, 8'd3, 32'h1234_5678, 4'hF, 1'b1, 8'd3);
        step();
        idle();
        @(negedge clk);
        check("busy_drop_v0", 32'(valid0), 32'h0);
        step();
        @(negedge clk);
        check("busy_drop_v1", 32'(valid1), 32'h0);
        repeat (49) step();
        check("mid_busy", 32'(busy0), 32'h1);
        rst = 1'b1;
        step();
        step();
        check("mid_rst_busy0", 32'(busy0), 32'h1);
        check("mid_rst_busy1", 32'(busy1), 32'h1);
        rst = 1'b0;
        wait_busy_low(cnt);
        check("restart_len", 32'(cnt), 32'd256);
        read_check("busy_write_dropped", 8'd3, 1'b0, 8'd0, 32'h0, 4'h0, 32'h0, 32'h0);

        repeat (3) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
